// File: rtl/incr16_cla.sv
// rtl/incr16_cla.sv - unsigned +1 incrementer with Sklansky prefix-AND carries and optional output register
module incr16_cla #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             cy
);

    localparam int LEVELS = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    // Reject illegal builds while elaborating rather than producing a silently wrong adder.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("incr16_cla: WIDTH must be at least 2");
        end
        if (LATENCY != 0 && LATENCY != 1) begin : g_bad_latency
            $error("incr16_cla: LATENCY must be 0 or 1");
        end
    endgenerate

    // pfx[l][i] holds AND of in[i:j] for the span resolved after l Sklansky levels;
    // pfx[LEVELS][i] is the full prefix AND of in[i:0].
    logic [LEVELS:0][WIDTH-1:0] pfx;
    logic [WIDTH:0]             carry;
    logic [WIDTH-1:0]           sum;
    logic                       carry_out;

    // Sklansky tree: at level l, every bit whose index has bit l set absorbs the
    // prefix of the top bit of the preceding 2^l block, so depth is ceil(log2(WIDTH)).
    always_comb begin
        pfx    = '0;
        pfx[0] = in;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) == 1) begin
                    pfx[l+1][i] = pfx[l][i] & pfx[l][((i >> l) << l) - 1];
                end else begin
                    pfx[l+1][i] = pfx[l][i];
                end
            end
        end
    end

    // Carry into bit i is the AND of all lower bits; the +1 supplies carry into bit 0.
    always_comb begin
        carry            = '0;
        carry[0]         = 1'b1;
        carry[WIDTH:1]   = pfx[LEVELS];
        sum              = in ^ carry[WIDTH-1:0];
        carry_out        = carry[WIDTH];
    end

    generate
        if (LATENCY == 1) begin : g_reg
            logic [WIDTH-1:0] out_d;
            logic [WIDTH-1:0] out_q;
            logic             cy_d;
            logic             cy_q;

            // Reset wins over capture so an in-flight result is dropped.
            always_comb begin
                out_d = sum;
                cy_d  = carry_out;
                if (rst) begin
                    out_d = '0;
                    cy_d  = 1'b0;
                end
            end

            // Output register stage.
            always_ff @(posedge clk) begin
                out_q <= out_d;
                cy_q  <= cy_d;
            end

            assign out = out_q;
            assign cy  = cy_q;
        end else begin : g_comb
            // Combinational build has no state; clk and rst are intentionally unused.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out            = sum;
            assign cy             = carry_out;
        end
    endgenerate

endmodule

// File: tb/tb_incr16_cla.sv
// tb/tb_incr16_cla.sv - scoreboard bench for incr16_cla in combinational, registered and odd-width builds
module tb_incr16_cla;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] in16  = '0;
    logic [15:0] out16;
    logic        cy16;
    logic [15:0] in16r = '0;
    logic [15:0] out16r;
    logic        cy16r;
    logic [4:0]  in5   = '0;
    logic [4:0]  out5;
    logic        cy5;
    logic [29:0] in30  = '0;
    logic [29:0] out30;
    logic        cy30;

    bit v16 = 0, v5 = 0, v30 = 0, vr_issue = 0, vr_q = 0;

    longint unsigned q16[$], q5[$], q30[$], qr[$];

    int n_pass  = 0;
    int n_total = 0;

    incr16_cla #(.WIDTH(16), .LATENCY(0)) u_c16 (.clk(clk), .rst(rst), .in(in16),  .out(out16),  .cy(cy16));
    incr16_cla #(.WIDTH(16), .LATENCY(1)) u_r16 (.clk(clk), .rst(rst), .in(in16r), .out(out16r), .cy(cy16r));
    incr16_cla #(.WIDTH(5),  .LATENCY(0)) u_c5  (.clk(clk), .rst(rst), .in(in5),   .out(out5),   .cy(cy5));
    incr16_cla #(.WIDTH(30), .LATENCY(0)) u_c30 (.clk(clk), .rst(rst), .in(in30),  .out(out30),  .cy(cy30));

    always #5 clk = ~clk;

    // Reference: {cy,out} is simply the operand plus one at WIDTH+1 bits.
    function automatic longint unsigned ref_inc(longint unsigned a, int w);
        longint unsigned mask;
        mask = (longint'(1) << w) - 1;
        return (a & mask) + 1;
    endfunction

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic pop_chk(string name, ref longint unsigned q[$], input longint unsigned act);
        if (q.size() == 0) chk({name, "_underflow"}, 1, 0);
        else chk(name, act, q.pop_front());
    endtask

    // Registered instance result becomes visible one edge after issue.
    always @(posedge clk) vr_q <= vr_issue;

    // Monitors: compare each presented result against the oldest expectation.
    always @(negedge clk) begin
        if (v16)  pop_chk("w16",  q16, {47'd0, cy16, out16});
        if (v5)   pop_chk("w5",   q5,  {58'd0, cy5, out5});
        if (v30)  pop_chk("w30",  q30, {33'd0, cy30, out30});
        if (vr_q) pop_chk("w16r", qr,  {47'd0, cy16r, out16r});
    end

    task automatic cyc_comb(bit e16, logic [15:0] a16, bit e5, logic [4:0] a5, bit e30, logic [29:0] a30);
        @(posedge clk); #1;
        in16 = a16; v16 = e16; if (e16) q16.push_back(ref_inc(a16, 16));
        in5  = a5;  v5  = e5;  if (e5)  q5.push_back(ref_inc(a5, 5));
        in30 = a30; v30 = e30; if (e30) q30.push_back(ref_inc(a30, 30));
    endtask

    task automatic cyc_reg(bit r, logic [15:0] a);
        @(posedge clk); #1;
        v16 = 0; v5 = 0; v30 = 0;
        rst = r; in16r = a; vr_issue = 1;
        qr.push_back(r ? 64'd0 : ref_inc(a, 16));
    endtask

    initial begin
        // Registered build: reset, capture, reset overriding capture, recovery.
        cyc_reg(1, 16'h0000);
        cyc_reg(1, 16'h0000);
        cyc_reg(0, 16'h1234);
        cyc_reg(1, 16'hFFFF);
        cyc_reg(0, 16'hFFFF);
        cyc_reg(0, 16'hFFFE);
        for (int i = 0; i < 40; i++) cyc_reg(($urandom_range(0, 7) == 0), 16'($urandom));
        @(posedge clk); #1;
        vr_issue = 0; rst = 0;

        // Directed boundaries.
        cyc_comb(1, 16'h0000, 1, 5'b11111, 1, 30'h3FFF_FFFF);
        cyc_comb(1, 16'h00FF, 1, 5'b01111, 1, 30'h0000_0000);
        cyc_comb(1, 16'h7FFF, 1, 5'b11110, 1, 30'h3FFF_FFFE);
        cyc_comb(1, 16'hFFFE, 1, 5'b00000, 1, 30'h1FFF_FFFF);
        cyc_comb(1, 16'hFFFF, 1, 5'b10111, 1, 30'h0000_FFFF);

        // Exhaustive 16-bit sweep alongside 5-bit wraps and 10k random 30-bit values.
        for (int i = 0; i < 65536; i++) begin
            cyc_comb(1, 16'(i), 1, 5'(i), (i < 10000), 30'($urandom));
        end

        @(posedge clk); #1;
        v16 = 0; v5 = 0; v30 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_w16",  q16.size(), 0);
        chk("drain_w5",   q5.size(),  0);
        chk("drain_w30",  q30.size(), 0);
        chk("drain_w16r", qr.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/incr16_cla.md
Name: incr16_cla

Overview:
- Unsigned +1 incrementer, 16 bits by default, with carry-out.
- Used by the next-instruction-pointer stage to form fetch_pc+1. Its word-address input excludes the 2 instruction-alignment bits, so an 18-bit byte address gives a 16-bit input.
- Carries are built with a parallel-prefix (Sklansky) AND tree, giving log2(WIDTH) logic depth.
- An optional output register stage exists. The default build is purely combinational, so the consumer can register the result in the same cycle.

Parameters:
- WIDTH, 16: operand width in bits. Must be at least 2. Non-power-of-2 values are legal.
- LATENCY, 0: 0 means combinational output. 1 means out and cy are registered on clk.

Ports:
- clk, input, 1: clock. Used only when LATENCY=1.
- rst, input, 1: reset, synchronous, active-high. Used only when LATENCY=1.
- in, input, WIDTH: operand.
- out, output, WIDTH: in + 1, modulo 2^WIDTH.
- cy, output, 1: carry-out. High exactly when in is all ones.

Behaviour:
- Arithmetic
  - {cy, out} = in + 1, computed at WIDTH+1 bits. Unsigned.
  - No saturation. All-ones wraps to zero with cy=1.
- Carry structure
  - c[0] = 1. c[i] = AND of in[i-1:0] for i = 1..WIDTH.
  - c[i] is computed by a prefix-AND tree with ceil(log2(WIDTH)) levels. A ripple chain is not allowed.
  - out[i] = in[i] XOR c[i]. cy = c[WIDTH].
- LATENCY=0
  - out and cy are pure combinational functions of in.
  - No state. clk and rst are ignored.
  - No X propagation on any known input. The output settles within one combinational path.
- LATENCY=1
  - out and cy are registered on the rising edge of clk.
  - A value presented on in appears on out/cy one cycle later.
  - When rst=1 at a clock edge: out <= 0 and cy <= 0. This overrides capture of in.
  - Reset asserted mid-stream discards the in-flight result.
  - On the first edge after rst deasserts, in is captured normally.
  - Before the first clock edge, outputs are undefined. Benches must apply reset first.
- Boundary conditions
  - in = 0 -> out = 1, cy = 0.
  - in = 2^WIDTH-2 -> out = all ones, cy = 0.
  - in = all ones -> out = 0, cy = 1.
  - Any value ending in k trailing ones flips exactly bits [k:0]; cy is 0 unless k = WIDTH.
- Any parameter value outside the legal set triggers an elaboration-time error.

Test Plan:
- LATENCY=0, WIDTH=16:
  - in = 0x0000 -> out = 0x0001, cy = 0.
  - in = 0x00FF -> out = 0x0100, cy = 0.
- LATENCY=0, WIDTH=16:
  - in = 0x7FFF -> out = 0x8000, cy = 0.
  - in = 0xFFFE -> out = 0xFFFF, cy = 0.
- LATENCY=0, WIDTH=16: in = 0xFFFF -> out = 0x0000, cy = 1.
- LATENCY=0, WIDTH=16: exhaustive sweep of in over 0x0000..0xFFFF -> {cy, out} == in + 1 at 17 bits, for every value.
- LATENCY=1, WIDTH=16:
  - Hold rst for 2 cycles -> out = 0, cy = 0.
  - Release rst and drive in = 0x1234 -> out = 0x1235 one cycle later.
  - Then drive in = 0xFFFF while asserting rst on the same edge -> out = 0, cy = 0.
- WIDTH=5 and WIDTH=30, LATENCY=0:
  - All-ones -> out = 0, cy = 1.
  - 0b01111 (WIDTH=5) -> 0b10000, cy = 0.
  - Random sweep of 10k values in the WIDTH=30 build -> matches the reference adder.
